add_rca_arb: RTL and testbench
==============================

Name: add_rca_arb

Overview:
- Shared-adder controller: arbitrates Reqs requesters onto one Slice-bit ripple-carry adder.
- Sequences each Bits-wide addition over Chunks = Bits/Slice cycles, carrying between slices.
- Returns sum, carry-out and requester id on a valid/ready response port.
- Sits between compute clients and the narrow adder, trading latency for area.

Parameters:
- Bits, 64, operand/result width; must be a multiple of Slice.
- Slice, 16, width of the shared adder slice; Chunks = Bits/Slice.
- Reqs, 4, number of requesters (>=2); IdW = $clog2(Reqs).

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  Reqs  per-requester request valid.
- req_ready  out  Reqs  per-requester accept; one-hot or zero.
- req_a  in  Reqs*Bits  operand A; requester i at [i*Bits +: Bits].
- req_b  in  Reqs*Bits  operand B, same packing.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IdW  index of the requester that owns the result.
- resp_sum  out  Bits  a+b mod 2^Bits.
- resp_carry  out  1  carry out of bit Bits-1.

Behaviour:
- Reset (reset==0, async): state=IDLE; chunk counter=0; carry register=0; rr pointer=0. Outputs: req_ready=0, resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0.
- Reset mid-operation aborts the transaction; the result is lost and the requester must re-issue.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - req_ready is combinational: one-hot grant to the first valid requester at or after rr pointer, modulo Reqs.
  - On grant (req_valid[g] & req_ready[g]): latch A, B and id=g; clear the carry register; set counter=0; set rr pointer=(g+1)%Reqs; go to RUN.
  - With no valid request, stay in IDLE and hold rr.
- RUN:
  - req_ready=0.
  - Each cycle, slice k=counter adds A[k*Slice +: Slice] + B[k*Slice +: Slice] + carry register.
  - Write the slice sum into result[k*Slice +: Slice] and the slice carry-out into the carry register; counter++.
  - When counter==Chunks-1, go to DONE after that cycle.
- DONE:
  - resp_valid=1; resp_sum, resp_carry and resp_id hold stable while resp_ready==0.
  - On resp_ready, go to IDLE; resp_valid drops the next cycle.
- Latency: grant at cycle T; RUN occupies T+1..T+Chunks; resp_valid is high from T+Chunks+1.
- Throughput: at most one op per Chunks+2 cycles. No new grant while in RUN or DONE.
- Slice==Bits: Chunks=1, exactly one RUN cycle.
- Operand changes after the grant have no effect, since operands are latched.
- Overflow: carry out of the top slice goes to resp_carry; the sum wraps modulo 2^Bits.
- Requesters drop req_valid only after a handshake. Fairness: every continuously-valid requester is granted within Reqs grants.

Optional Feature:
- Macro ADD_RCA_ARB_SUB_EN.
- Defined:
  - Adds port req_sub (in, Reqs), latched at grant.
  - For sub ops, B is inverted bitwise at latch and the carry register initialises to 1, giving a-b.
  - resp_carry=1 means no borrow (a>=b unsigned).
- Undefined: port absent; add only; initial carry is always 0.

Decomposition:
- Package add_rca_arb_pkg holds:
  - FSM state enum {IDLE, RUN, DONE} (2-bit typedef);
  - function for the rr pointer width;
  - localparam helper computing Chunks.
- One sub-module, add_rca_cin: a Slice-bit combinational ripple-carry adder with a cin input (sum, cout). The controller instantiates it once.
- The round-robin pick stays inline.

Test Plan:
- Defaults, only req 2 valid, a=0x0000_0001_FFFF_FFFF, b=1 -> req_ready=4'b0100 in the same cycle; resp_valid exactly 5 cycles later; sum=0x0000_0002_0000_0000, carry=0, id=2. Carry crosses the slice-1/slice-2 boundary.
- a=all-ones, b=1 -> sum=0, carry=1; the carry propagates through all 4 slices.
- All 4 requesters continuously valid, resp_ready=1 -> grant order 0,1,2,3,0; each op is 6 cycles apart.
- Hold resp_ready=0 for 10 cycles in DONE -> outputs stable, req_ready stays 0. Raise resp_ready -> resp_valid low next cycle, then the next grant.
- Assert reset low during RUN (counter=2) -> all outputs 0 immediately. After release, rr=0 and the next grant goes to the lowest-index valid requester.
- With ADD_RCA_ARB_SUB_EN: a=5, b=7, sub=1 -> sum=2^64-2, carry=0. With a=7, b=5 -> sum=2, carry=1.

Source files
------------

// File: rtl/add_rca_arb_pkg.sv
// Shared types and sizing helpers for the add_rca_arb shared-adder controller.
package add_rca_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of an index/pointer over n entries (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of adder-slice passes needed for one full-width addition.
    function automatic int unsigned chunks_of(input int unsigned bits, input int unsigned slice);
        return bits / slice;
    endfunction

endpackage

// File: rtl/add_rca_arb_if.sv
// Request/response bus of add_rca_arb; req_sub exists only with ADD_RCA_ARB_SUB_EN.
interface add_rca_arb_if
    import add_rca_arb_pkg::*;
#(
    parameter int unsigned BITS = 64,
    parameter int unsigned REQS = 4
);
    localparam int unsigned IDW = ptr_w(REQS);

    logic [REQS-1:0]      req_valid;
    logic [REQS-1:0]      req_ready;
    logic [REQS*BITS-1:0] req_a;
    logic [REQS*BITS-1:0] req_b;
`ifdef ADD_RCA_ARB_SUB_EN
    logic [REQS-1:0]      req_sub;
`endif
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [BITS-1:0]      resp_sum;
    logic                 resp_carry;

`ifdef ADD_RCA_ARB_SUB_EN
    modport master (
        output req_valid, req_a, req_b, req_sub, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_carry
    );
    modport slave (
        input  req_valid, req_a, req_b, req_sub, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_carry
    );
`else
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_carry
    );
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_carry
    );
`endif

endinterface

// File: rtl/add_rca_cin.sv
// Combinational W-bit ripple-carry adder with carry-in.
module add_rca_cin #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic c;

    // Bit-serial ripple; a scalar carry avoids a self-referencing vector.
    always_comb begin
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/add_rca_arb.sv
// Round-robin arbiter sharing one SLICE-bit adder across REQS requesters.
// Optional subtract mode with ADD_RCA_ARB_SUB_EN.
module add_rca_arb
    import add_rca_arb_pkg::*;
#(
    parameter int unsigned BITS  = 64,
    parameter int unsigned SLICE = 16,
    parameter int unsigned REQS  = 4
) (
    input  logic         clk,
    input  logic         reset,
    add_rca_arb_if.slave bus
);

    localparam int unsigned CHUNKS = chunks_of(BITS, SLICE);
    localparam int unsigned IDW    = ptr_w(REQS);
    localparam int unsigned CW     = ptr_w(CHUNKS);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [BITS-1:0] a_q, a_d;
    logic [BITS-1:0] b_q, b_d;
    logic [BITS-1:0] sum_q, sum_d;
    logic            valid_q, valid_d;
    logic [REQS-1:0] ready_c;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  cand;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;

    add_rca_cin #(.W(SLICE)) u_slice (
        .a    (a_q[cnt_q*SLICE +: SLICE]),
        .b    (b_q[cnt_q*SLICE +: SLICE]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // First valid requester at or after the rr pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < REQS; i++) begin
            cand = IDW'((32'(rr_q) + i) % REQS);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    // Next-state, datapath updates and grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        rr_d    = rr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        ready_c = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    ready_c[pick_idx] = 1'b1;
                    a_d     = bus.req_a[pick_idx*BITS +: BITS];
                    id_d    = pick_idx;
                    cnt_d   = '0;
                    rr_d    = IDW'((32'(pick_idx) + 32'd1) % REQS);
                    state_d = RUN;
`ifdef ADD_RCA_ARB_SUB_EN
                    // a - b as a + ~b + 1; final carry 1 means no borrow.
                    b_d     = bus.req_sub[pick_idx] ? ~bus.req_b[pick_idx*BITS +: BITS]
                                                    :  bus.req_b[pick_idx*BITS +: BITS];
                    carry_d = bus.req_sub[pick_idx];
`else
                    b_d     = bus.req_b[pick_idx*BITS +: BITS];
                    carry_d = 1'b0;
`endif
                end
            end
            RUN: begin
                sum_d[cnt_q*SLICE +: SLICE] = slice_sum;
                carry_d = slice_cout;
                if (cnt_q == CW'(CHUNKS - 1)) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant is combinational; forced low while reset is asserted.
    assign bus.req_ready  = reset ? ready_c : '0;
    assign bus.resp_valid = valid_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_carry = carry_q;
    assign bus.resp_id    = id_q;

endmodule

// File: tb/tb_add_rca_arb.sv
// Directed + randomized bench for add_rca_arb against an arithmetic reference model.
module tb_add_rca_arb;

    localparam int unsigned BITS   = 64;
    localparam int unsigned SLICE  = 16;
    localparam int unsigned REQS   = 4;
    localparam int unsigned CHUNKS = BITS / SLICE;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    add_rca_arb_if #(.BITS(BITS), .REQS(REQS)) ifc ();

    add_rca_arb #(.BITS(BITS), .SLICE(SLICE), .REQS(REQS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rr_m     = 0;

    logic [BITS-1:0] op_a   [REQS];
    logic [BITS-1:0] op_b   [REQS];
    logic            op_sub [REQS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on full-width operands.
    function automatic logic [BITS:0] model(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                            input logic sub);
        if (sub) return {(a >= b) ? 1'b1 : 1'b0, a - b};
        return (BITS+1)'(a) + (BITS+1)'(b);
    endfunction

    // Reference round-robin: first set bit of mask at or after rr.
    function automatic int pick(input logic [REQS-1:0] mask, input int rr);
        for (int i = 0; i < int'(REQS); i++) begin
            if (mask[(rr + i) % int'(REQS)]) return (rr + i) % int'(REQS);
        end
        return -1;
    endfunction

    function automatic logic [REQS-1:0] onehot(input int idx);
        logic [REQS-1:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    task automatic drive(input int r);
        ifc.req_a[r*BITS +: BITS] = op_a[r];
        ifc.req_b[r*BITS +: BITS] = op_b[r];
`ifdef ADD_RCA_ARB_SUB_EN
        ifc.req_sub[r] = op_sub[r];
`endif
    endtask

    task automatic scramble(input int r);
        op_a[r] = {$urandom, $urandom};
        op_b[r] = {$urandom, $urandom};
`ifdef ADD_RCA_ARB_SUB_EN
        op_sub[r] = 1'($urandom_range(0, 1));
`endif
        drive(r);
    endtask

    // Returns n = cycles after the grant cycle at which resp_valid is first seen.
    task automatic wait_resp(input string tag, output int n);
        n = 1;
        while (!ifc.resp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ifc.resp_valid) check({tag, "_timeout"}, 128'(0), 128'(1));
    endtask

    // One transaction from requester g; other>=0 raises that requester during the hold.
    task automatic op(input int g, input int hold, input int other);
        logic [BITS:0] e;
        int            n;
        ifc.req_valid = ifc.req_valid | onehot(g);
        drive(g);
        #1;
        check("grant", 128'(ifc.req_ready), 128'(onehot(pick(ifc.req_valid, rr_m))));
        e = model(op_a[g], op_b[g], op_sub[g]);
        @(posedge clk); #1;
        ifc.req_valid = ifc.req_valid & ~onehot(g);
        rr_m = (g + 1) % int'(REQS);
        scramble(g);
        wait_resp("resp", n);
        check("latency", 128'(n), 128'(CHUNKS + 1));
        check("sum",     128'(ifc.resp_sum),   128'(e[BITS-1:0]));
        check("carry",   128'(ifc.resp_carry), 128'(e[BITS]));
        check("id",      128'(ifc.resp_id),    128'(g));
        if (other >= 0) begin
            ifc.req_valid = ifc.req_valid | onehot(other);
            scramble(other);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 128'(ifc.resp_valid), 128'(1));
            check("hold_sum",   128'(ifc.resp_sum),   128'(e[BITS-1:0]));
            check("hold_carry", 128'(ifc.resp_carry), 128'(e[BITS]));
            check("hold_id",    128'(ifc.resp_id),    128'(g));
            check("hold_ready", 128'(ifc.req_ready),  128'(0));
        end
        ifc.resp_ready = 1'b1;
        @(posedge clk); #1;
        ifc.resp_ready = 1'b0;
        check("resp_drop", 128'(ifc.resp_valid), 128'(0));
        if (other >= 0)
            check("next_grant", 128'(ifc.req_ready), 128'(onehot(pick(ifc.req_valid, rr_m))));
    endtask

    initial begin
        int            n, g, t, t_prev, nw;
        logic [BITS:0] e;

        ifc.req_valid  = '0;
        ifc.req_a      = '0;
        ifc.req_b      = '0;
        ifc.resp_ready = 1'b0;
`ifdef ADD_RCA_ARB_SUB_EN
        ifc.req_sub    = '0;
`endif
        for (int r = 0; r < int'(REQS); r++) begin
            op_a[r] = '0; op_b[r] = '0; op_sub[r] = 1'b0;
        end

        // Reset state, with requests pending.
        ifc.req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 128'(ifc.req_ready),  128'(0));
        check("rst_valid", 128'(ifc.resp_valid), 128'(0));
        check("rst_sum",   128'(ifc.resp_sum),   128'(0));
        check("rst_carry", 128'(ifc.resp_carry), 128'(0));
        check("rst_id",    128'(ifc.resp_id),    128'(0));
        ifc.req_valid = '0;
        reset = 1'b1;
        rr_m  = 0;
        @(posedge clk); #1;

        // Carry across the slice-1/slice-2 boundary.
        op_a[2] = 64'h0000_0001_FFFF_FFFF; op_b[2] = 64'd1; op_sub[2] = 1'b0;
        op(2, 0, -1);
        // Carry through all slices, overflow.
        op_a[0] = '1; op_b[0] = 64'd1; op_sub[0] = 1'b0;
        op(0, 0, -1);
        // Hold in DONE for 10 cycles, with another requester waiting.
        op_a[1] = {$urandom, $urandom}; op_b[1] = {$urandom, $urandom}; op_sub[1] = 1'b0;
        op(1, 10, 2);
        op(2, 0, -1);

        // Randomized traffic.
        for (int k = 0; k < 12; k++) begin
            g = $urandom_range(0, REQS - 1);
            op_a[g] = {$urandom, $urandom};
            op_b[g] = (k % 4 == 3) ? ~op_a[g] : {$urandom, $urandom};
            op_sub[g] = 1'b0;
            op(g, $urandom_range(0, 2), -1);
        end

        // Reset mid-RUN (counter==2); afterwards rr restarts at 0.
        ifc.req_valid = onehot(2);
        op_a[2] = {$urandom, $urandom}; op_b[2] = {$urandom, $urandom}; op_sub[2] = 1'b0;
        drive(2);
        #1;
        check("pre_rst_grant", 128'(ifc.req_ready), 128'(onehot(pick(ifc.req_valid, rr_m))));
        @(posedge clk); #1;
        ifc.req_valid = onehot(1) | onehot(3);
        scramble(1); scramble(3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("run_ready", 128'(ifc.req_ready), 128'(0));
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 128'(ifc.req_ready),  128'(0));
        check("mid_rst_valid", 128'(ifc.resp_valid), 128'(0));
        check("mid_rst_sum",   128'(ifc.resp_sum),   128'(0));
        check("mid_rst_carry", 128'(ifc.resp_carry), 128'(0));
        check("mid_rst_id",    128'(ifc.resp_id),    128'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        rr_m  = 0;
        #1;
        check("post_rst_grant", 128'(ifc.req_ready), 128'(onehot(pick(ifc.req_valid, rr_m))));
        ifc.req_valid = '0;
        #1;
        op(1, 0, -1);

        // All requesters continuously valid, consumer always ready.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        rr_m  = 0;
        for (int r = 0; r < int'(REQS); r++) begin
            op_sub[r] = 1'b0;
            scramble(r);
            op_sub[r] = 1'b0;
            drive(r);
        end
        ifc.req_valid  = '1;
        ifc.resp_ready = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            nw = 0;
            #1;
            while (ifc.req_ready == '0 && nw < 20) begin
                @(posedge clk); #2;
                nw++;
            end
            g = pick(ifc.req_valid, rr_m);
            check("rr_grant", 128'(ifc.req_ready), 128'(onehot(g)));
            check("rr_order", 128'(g), 128'(k % int'(REQS)));
            t = cyc;
            if (k > 0) check("rr_gap", 128'(t - t_prev), 128'(CHUNKS + 2));
            t_prev = t;
            e = model(op_a[g], op_b[g], 1'b0);
            @(posedge clk); #1;
            rr_m = (g + 1) % int'(REQS);
            scramble(g);
            op_sub[g] = 1'b0;
            drive(g);
            wait_resp("rr_resp", n);
            check("rr_sum", 128'(ifc.resp_sum), 128'(e[BITS-1:0]));
            check("rr_id",  128'(ifc.resp_id),  128'(g));
        end
        ifc.resp_ready = 1'b0;
        ifc.req_valid  = '0;

`ifdef ADD_RCA_ARB_SUB_EN
        // Reset again so the next transaction starts from IDLE.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        rr_m  = 0;
        op_a[0] = 64'd5; op_b[0] = 64'd7; op_sub[0] = 1'b1;
        op(0, 0, -1);
        op_a[1] = 64'd7; op_b[1] = 64'd5; op_sub[1] = 1'b1;
        op(1, 0, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
